// File: rtl/paralelo_serie_tx_pkg.sv
//------------------------------------------------------------------------------
// Module   : paralelo_serie_tx_pkg
// Purpose  : Constants and types shared by the parallel-to-serial transmitter:
//            the comma byte used for link sync / idle fill and the transmitter
//            state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package paralelo_serie_tx_pkg;

  // Comma byte: sent for link synchronisation and as idle fill.
  localparam logic [7:0] c_comma_byte = 8'hBC;

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } ps_state_t;

endpackage

`default_nettype wire

// File: rtl/paralelo_serie_tx_if.sv
//------------------------------------------------------------------------------
// Module   : paralelo_serie_tx_if
// Purpose  : Bundles the byte-input handshake and the serial-side outputs of
//            paralelo_serie_tx.
//   data_in   [7:0]  byte to transmit               (master -> slave)
//   valid_in         data_in valid                   (master -> slave)
//   ready_out        transmitter can take a byte     (slave -> master)
//   data_out         serial stream, MSB first        (slave -> master)
//   active_tx        sync commas sent                (slave -> master)
//   bit_cnt   [2:0]  position of current data_out bit (slave -> master)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface paralelo_serie_tx_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active_tx;
  logic [2:0] bit_cnt;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  active_tx,
    input  bit_cnt
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output active_tx,
    output bit_cnt
  );

endinterface

`default_nettype wire

// File: rtl/paralelo_serie_tx_fifo.sv
//------------------------------------------------------------------------------
// Module   : paralelo_serie_tx_fifo
// Purpose  : DEPTH x 8 synchronous FIFO buffering bytes ahead of the shifter.
//   clk_32f  in   clock
//   reset_L  in   asynchronous reset, active low (flushes the FIFO)
//   push     in   write din
//   pop      in   discard head entry
//   din      in   [7:0] write data
//   dout     out  [7:0] head entry (valid when !empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   count    out  number of entries held
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module paralelo_serie_tx_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                         clk_32f,
  input  logic                         reset_L,
  input  logic                         push,
  input  logic                         pop,
  input  logic [7:0]                   din,
  output logic [7:0]                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = pop & (r_cnt != '0);
  // A full FIFO can still take a byte when the head leaves on the same edge.
  assign w_do_push = push & ((r_cnt != c_depth) | w_do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_32f) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_cnt == c_depth);
  assign empty = (r_cnt == '0);
  assign count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/paralelo_serie_tx.sv
//------------------------------------------------------------------------------
// Module   : paralelo_serie_tx
// Purpose  : Byte-parallel to bit-serial transmitter. Buffers input bytes and
//            shifts them out MSB first, one bit per clk_32f edge. After reset
//            SYNC_BYTES commas (0xBC) are sent, then buffered data; an empty
//            buffer at a byte boundary sends an idle comma.
//   clk_32f   in   serial bit clock
//   reset_L   in   asynchronous reset, active low
//   bus       slave modport of paralelo_serie_tx_if
//             (data_in, valid_in, ready_out, data_out, active_tx, bit_cnt)
// Build option:
//   PS_COMMA_INSERT_EN  when defined, a comma is forced after every
//                       COMMA_PERIOD consecutive data bytes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module paralelo_serie_tx #(
  parameter int SYNC_BYTES   = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int COMMA_PERIOD = 16
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  paralelo_serie_tx_if.slave   bus
);

  import paralelo_serie_tx_pkg::*;

  localparam int SW = $clog2(SYNC_BYTES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] c_sync_last   = SW'(SYNC_BYTES - 1);
  localparam logic [CW-1:0] c_depth_m1    = CW'(FIFO_DEPTH - 1);

  // Registered state
  ps_state_t     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_data_out;
  logic          r_ready;
  logic [SW-1:0] r_sync;

  // Combinational next-state / control
  ps_state_t     w_state_nxt;
  logic [SW-1:0] w_sync_nxt;
  logic          w_boundary;
  logic          w_push;
  logic          w_pop;
  logic          w_ready_nxt;
  logic [7:0]    w_load_byte;

  // FIFO side
  logic [7:0]    w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

`ifdef PS_COMMA_INSERT_EN
  localparam int IW = $clog2(COMMA_PERIOD + 1);
  localparam logic [IW-1:0] c_ins_period = IW'(COMMA_PERIOD);
  logic [IW-1:0] r_ins;
  logic [IW-1:0] w_ins_nxt;
`else
  localparam int c_unused_comma_period = COMMA_PERIOD;
`endif

  paralelo_serie_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .push    (w_push),
    .pop     (w_pop),
    .din     (bus.data_in),
    .dout    (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // Next-state, byte selection and FIFO control
  always_comb begin
    w_boundary  = (r_bit_cnt == 3'd7);
    w_push      = bus.valid_in & r_ready;
    w_pop       = 1'b0;
    w_load_byte = c_comma_byte;
    w_state_nxt = r_state;
    w_sync_nxt  = r_sync;
`ifdef PS_COMMA_INSERT_EN
    w_ins_nxt   = r_ins;
`endif
    if (w_boundary) begin
      case (r_state)
        ST_SYNC: begin
          w_sync_nxt = r_sync + SW'(1);
          // Leaving on the last comma's load edge raises active_tx with it.
          if (r_sync == c_sync_last) w_state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
`ifdef PS_COMMA_INSERT_EN
          if (r_ins == c_ins_period) begin
            w_ins_nxt = '0;               // forced comma, FIFO left untouched
          end else if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_load_byte = w_fifo_dout;
            w_ins_nxt   = r_ins + IW'(1);
          end else begin
            w_ins_nxt = '0;               // idle comma also restarts the run
          end
`else
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_load_byte = w_fifo_dout;
          end
`endif
        end
        default: w_state_nxt = ST_SYNC;
      endcase
    end
    // ready_out reflects the occupancy after this edge's push/pop.
    w_ready_nxt = w_pop | ~(w_fifo_full | (w_push & (w_fifo_count == c_depth_m1)));
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_SYNC;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_data_out <= 1'b0;
      r_ready    <= 1'b0;
      r_sync     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync    <= w_sync_nxt;
      r_ready   <= w_ready_nxt;
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_boundary) begin
        // MSB goes straight to the output register so bit_cnt=0 shows bit 7.
        r_shift    <= w_load_byte;
        r_data_out <= w_load_byte[7];
      end else begin
        r_shift    <= {r_shift[6:0], 1'b0};
        r_data_out <= r_shift[6];
      end
    end
  end

`ifdef PS_COMMA_INSERT_EN
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) r_ins <= '0;
    else          r_ins <= w_ins_nxt;
  end
`endif

  assign bus.ready_out = r_ready;
  assign bus.data_out  = r_data_out;
  assign bus.active_tx = (r_state == ST_ACTIVE);
  assign bus.bit_cnt   = r_bit_cnt;

endmodule

`default_nettype wire
